snake_step_ctrl: RTL
====================

# snake_step_ctrl

Per-frame motion controller for the 4-segment snake. It sits between the PS/2 byte stream and the pixel-mapping stage, and owns the segment coordinate registers (Px1..Py4) and the AllBlack flag. On each frame-rate tick it advances the snake one cell on the 64×48 cell grid (640×480 at 10 px/cell). Between ticks it latches keyboard direction, pause and escape commands.

## Interface
- GRID_W, 64, columns; x range 0..GRID_W-1
- GRID_H, 48, rows; y range 0..GRID_H-1
- START_X, 32, head x after reset/escape
- START_Y, 24, head y after reset/escape
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle frame strobe, synchronous to clk (frame-rate divider output)
- key_valid  in  1  one-cycle strobe: key_code holds a completed PS/2 byte
- key_code  in  8  PS/2 set-2 byte
- px1..px4  out  6 each  segment x; px1 is the head
- py1..py4  out  6 each  segment y
- all_black  out  1  1 = renderer blanks the screen
- step  out  1  one-cycle pulse, high in the cycle the new positions are visible
- state  out  2  00 BLACK, 01 RUN, 10 PAUSE

## Operation
- Reset values:
  - State BLACK, all_black=1, step=0.
  - Direction RIGHT.
  - Segments: (START_X,START_Y), (START_X-1,START_Y), (START_X-2,START_Y), (START_X-3,START_Y).
- Key decode:
  - 0xF0 sets a break flag; the next byte is discarded and clears the flag.
  - Make codes: 0x1D up, 0x1B down, 0x1C left, 0x23 right, 0x29 space, 0x76 escape. Other bytes are ignored.
- Direction latch:
  - A direction key writes pending_dir unless it is the reverse of the committed direction. Reverse keys are dropped.
  - Several keys before one tick: the last accepted key wins.
- State machine:
  - BLACK: a direction key moves to RUN (direction applied per the latch rule) and clears all_black. Ticks are ignored.
  - RUN: each tick commits pending_dir and performs one step. Space moves to PAUSE. Escape moves to BLACK.
  - PAUSE: ticks are ignored and positions are held. Space returns to RUN. Escape moves to BLACK. Direction keys still update pending_dir.
  - Escape always forces BLACK, sets all_black=1, and reloads the reset positions and direction.
- Step:
  - Segments shift: seg4←seg3, seg3←seg2, seg2←seg1, then seg1←head+dir.
  - Up is y-1; down is y+1.
- Arithmetic:
  - 6-bit unsigned.
  - x wraps naturally mod 64 when GRID_W=64. Otherwise compare explicitly: x=GRID_W-1 going right→0; x=0 going left→GRID_W-1.
  - y=GRID_H-1 going down→0; y=0 going up→GRID_H-1. y never holds 48..63.

## Timing
- tick sampled at edge N: positions and step are valid after edge N+1, giving 1-cycle latency. step is high for exactly one cycle.
- tick and key_valid in the same cycle: the step uses the direction committed before that cycle; the new key applies from the next tick.
- tick and escape in the same cycle: escape wins, no step and no step pulse.
- tick and space in the same cycle while in RUN: the step occurs and the state then becomes PAUSE.
- Key effects on state and all_black take effect after the edge following key_valid.
- rst asserted mid-step or mid-break-sequence: all registers, including the break flag and pending_dir, return to reset values at the next edge.
- Outputs are registered and glitch-free for the renderer.

## Configuration
- SNAKE_WRAP_EN:
  - Defined: wall wrap-around as described in Operation.
  - Undefined: a step whose head would leave the grid is a game over:
    - No positions change.
    - State goes to BLACK and all_black=1.
    - Positions are reloaded to reset values on the following cycle.
    - step is not pulsed.

## Test plan
- Reset, key 0x23, then 3 ticks → state=01; head (35,24), tail (32,24); 3 step pulses, each 1 cycle after its tick.
- In RUN going right, keys 0x1C then 0x1D before a tick → left is dropped, up is accepted; next tick gives head (x,23) with x unchanged.
- Head at (63,10) going right, one tick → with SNAKE_WRAP_EN: head (0,10). Without it: state=00, all_black=1, positions reloaded to the reset pattern.
- Head at (5,0) going up, one tick → head (5,47) with SNAKE_WRAP_EN.
- Sequence 0xF0,0x29 in RUN → no pause. Then 0x29 → PAUSE; 5 ticks give no step and unchanged positions. Then 0x29 → RUN.
- tick and key 0x76 in the same cycle while in RUN → no step pulse; next cycle state=00, all_black=1, reset positions. rst pulse mid-run gives the same result.

Source files
------------

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: per-frame motion controller for a 4-segment snake on a GRID_W x GRID_H cell grid.
//   Inputs : clk, rst (sync, active-high), tick (frame strobe), key_valid/key_code (PS/2 set-2 bytes)
//   Outputs: px1..px4/py1..py4 (segment cells, px1/py1 = head), all_black (blank screen),
//            step (1-cycle pulse with new positions), state (00 BLACK, 01 RUN, 10 PAUSE)
//   Build  : define SNAKE_WRAP_EN for wall wrap-around; otherwise leaving the grid is game over.
module snake_step_ctrl #(
   parameter int GRID_W  = 64,
   parameter int GRID_H  = 48,
   parameter int START_X = 32,
   parameter int START_Y = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic [5:0] px1,
   output logic [5:0] px2,
   output logic [5:0] px3,
   output logic [5:0] px4,
   output logic [5:0] py1,
   output logic [5:0] py2,
   output logic [5:0] py3,
   output logic [5:0] py4,
   output logic       all_black,
   output logic       step,
   output logic [1:0] state
);
   localparam logic [1:0] BLACK = 2'd0, RUN = 2'd1, PAUSE = 2'd2;
   // Opposite directions differ only in bit 0, so reverse(d) = d ^ 1.
   localparam logic [1:0] D_R = 2'd0, D_L = 2'd1, D_U = 2'd2, D_D = 2'd3;
   localparam logic [5:0] XMAX = 6'(GRID_W - 1);
   localparam logic [5:0] YMAX = 6'(GRID_H - 1);
   localparam logic [5:0] SX0 = 6'(START_X), SX1 = 6'(START_X - 1);
   localparam logic [5:0] SX2 = 6'(START_X - 2), SX3 = 6'(START_X - 3);
   localparam logic [5:0] SY = 6'(START_Y);

   logic       brk, reload;
   logic [1:0] dir, pend, kdir, base;
   logic       make, is_dir, space, esc, adv, accept, hit, over, do_step;
   logic [5:0] nx, ny;

   always_comb begin
      make    = key_valid && !brk && key_code != 8'hF0;
      is_dir  = make && (key_code == 8'h1D || key_code == 8'h1B ||
                         key_code == 8'h1C || key_code == 8'h23);
      kdir    = key_code == 8'h1D ? D_U : key_code == 8'h1B ? D_D :
                key_code == 8'h1C ? D_L : D_R;
      space   = make && key_code == 8'h29;
      esc     = make && key_code == 8'h76;
      adv     = tick && state == RUN;
      // A key is judged against the direction that is committed once this edge has passed.
      base    = reload ? D_R : adv ? pend : dir;
      accept  = is_dir && kdir != (base ^ 2'b01);
      hit     = (pend == D_R && px1 == XMAX) || (pend == D_L && px1 == 6'd0) ||
                (pend == D_U && py1 == 6'd0) || (pend == D_D && py1 == YMAX);
      nx      = pend == D_R ? (px1 == XMAX ? 6'd0 : px1 + 6'd1) :
                pend == D_L ? (px1 == 6'd0 ? XMAX : px1 - 6'd1) : px1;
      ny      = pend == D_D ? (py1 == YMAX ? 6'd0 : py1 + 6'd1) :
                pend == D_U ? (py1 == 6'd0 ? YMAX : py1 - 6'd1) : py1;
`ifdef SNAKE_WRAP_EN
      over    = 1'b0;
`else
      over    = hit;
`endif
      do_step = adv && !esc && !over;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BLACK;
         all_black <= 1'b1;
         step <= 1'b0;
         brk <= 1'b0;
         reload <= 1'b0;
         dir <= D_R;
         pend <= D_R;
         px1 <= SX0; px2 <= SX1; px3 <= SX2; px4 <= SX3;
         py1 <= SY;  py2 <= SY;  py3 <= SY;  py4 <= SY;
      end else begin
         step <= do_step;
         // Game over freezes the positions for one cycle, then reloads them.
         reload <= adv && over && !esc;
         if (key_valid)
            brk <= !brk && key_code == 8'hF0;
         if (esc || reload) begin
            dir <= D_R;
            px1 <= SX0; px2 <= SX1; px3 <= SX2; px4 <= SX3;
            py1 <= SY;  py2 <= SY;  py3 <= SY;  py4 <= SY;
         end else if (do_step) begin
            dir <= pend;
            px4 <= px3; px3 <= px2; px2 <= px1; px1 <= nx;
            py4 <= py3; py3 <= py2; py2 <= py1; py1 <= ny;
         end
         pend <= esc ? D_R : accept ? kdir : reload ? D_R : pend;
         if (esc || (adv && over)) begin
            state <= BLACK;
            all_black <= 1'b1;
         end else if (state == BLACK && is_dir) begin
            state <= RUN;
            all_black <= 1'b0;
         end else if (space && state == RUN)
            state <= PAUSE;
         else if (space && state == PAUSE)
            state <= RUN;
      end
   end
endmodule
